// File: rtl/memory_unit_sync.sv
// memory_unit_sync: single-port scratch RAM with registered read, read-valid strobe and clear sweeper
module memory_unit_sync #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op,
    input  logic              sel,
    input  logic              clear,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  in_bus,
    output logic [WIDTH-1:0]  out_bus,
    output logic              out_valid,
    output logic              busy,
    output logic [WIDTH-1:0]  stored_value
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              in_range;
    // Extra bit keeps the bound representable when DEPTH is a power of two
    assign in_range     = {1'b0, address} < (ADDR_W+1)'(DEPTH);
    assign stored_value = in_range ? mem[address] : '0;
    assign busy         = state == CLEAR;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            cnt       <= '0;
            out_bus   <= '0;
            out_valid <= 1'b0;
        end else if (state == CLEAR) begin
            mem[cnt]  <= '0;
            cnt       <= cnt + 1'b1;
            out_valid <= 1'b0;
            if (cnt == ADDR_W'(DEPTH - 1)) state <= IDLE;
        end else begin
            out_valid <= sel && !op;
            if (sel && op && in_range) mem[address] <= in_bus;
            if (sel && !op) out_bus <= in_range ? mem[address] : '0;
            // A request sharing the cycle with clear completes before the sweep begins
            if (clear) begin
                state <= CLEAR;
                cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_memory_unit_sync.sv
// tb_memory_unit_sync: checks an 8x8 and a 4-bit x 5-word instance against a behavioural model
module tb_memory_unit_sync;
    logic       clk = 0;
    logic       rst = 0, op = 0, sel = 0, clear = 0;
    logic [2:0] address = 0;
    logic [7:0] in_bus = 0;
    logic [7:0] o8, s8;
    logic [3:0] o5, s5;
    logic       v8, v5, b8, b5;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    memory_unit_sync dut8 (
        .clk(clk), .rst(rst), .op(op), .sel(sel), .clear(clear), .address(address),
        .in_bus(in_bus), .out_bus(o8), .out_valid(v8), .busy(b8), .stored_value(s8)
    );
    memory_unit_sync #(.WIDTH(4), .DEPTH(5)) dut5 (
        .clk(clk), .rst(rst), .op(op), .sel(sel), .clear(clear), .address(address),
        .in_bus(in_bus[3:0]), .out_bus(o5), .out_valid(v5), .busy(b5), .stored_value(s5)
    );

    // Reference: index 0 = 8x8 instance, index 1 = 4x5 instance
    logic [7:0] mm [2][8];
    logic [7:0] om [2];
    logic       vm [2];
    int         left [2];
    int         dep [2] = '{8, 5};
    logic [7:0] msk [2] = '{8'hff, 8'h0f};

    function automatic logic [7:0] peek(int k, int a);
        return a < dep[k] ? mm[k][a] : 8'h00;
    endfunction

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                left[k] = dep[k];
                om[k] = 0;
                vm[k] = 0;
            end else if (left[k] > 0) begin
                mm[k][dep[k] - left[k]] = 0;
                left[k]--;
                vm[k] = 0;
            end else begin
                vm[k] = 0;
                if (sel && op && address < dep[k]) mm[k][address] = in_bus & msk[k];
                if (sel && !op) begin
                    om[k] = peek(k, address);
                    vm[k] = 1;
                end
                if (clear) left[k] = dep[k];
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int n8 = 0, n5 = 0, pv = 0;
        rst = 1;
        step();
        rst = 0;
        total++; if (o8 !== 8'h00 || v8 !== 1'b0) begin bad++; $display("FAIL reset_out got out=%h valid=%b want 00/0", o8, v8); end
        for (int i = 0; i < 12; i++) begin
            if (b8) n8++;
            if (b5) n5++;
            if (v8 || v5) pv++;
            step();
        end
        total++; if (n8 != 8) begin bad++; $display("FAIL sweep_len8 got %0d want 8", n8); end
        total++; if (n5 != 5) begin bad++; $display("FAIL sweep_len5 got %0d want 5", n5); end
        total++; if (pv != 0) begin bad++; $display("FAIL sweep_valid got %0d pulses want 0", pv); end
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            total++; if (s8 !== 8'h00 || s5 !== 4'h0) begin bad++; $display("FAIL cleared_%0d got %h/%h want 00/0", a, s8, s5); end
        end
    endtask

    task automatic test_write_read();
        sel = 1; op = 1; address = 3; in_bus = 8'h55;
        step();
        sel = 0;
        total++; if (s8 !== 8'h55 || s5 !== 4'h5) begin bad++; $display("FAIL wr_stored got %h/%h want 55/5", s8, s5); end
        total++; if (v8 !== 1'b0) begin bad++; $display("FAIL wr_valid got %b want 0", v8); end
        sel = 1; op = 0;
        step();
        sel = 0;
        total++; if (o8 !== 8'h55 || v8 !== 1'b1) begin bad++; $display("FAIL rd_data got %h/%b want 55/1", o8, v8); end
        step();
        total++; if (o8 !== 8'h55 || v8 !== 1'b0) begin bad++; $display("FAIL rd_hold got %h/%b want 55/0", o8, v8); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e8 [3] = '{8'ha5, 8'h3c, 8'ha5};
        logic [3:0] e5 [3] = '{4'h5, 4'h0, 4'h5};
        logic [2:0] ra [3] = '{3'd0, 3'd7, 3'd0};
        sel = 1; op = 1; address = 0; in_bus = 8'ha5;
        step();
        address = 7; in_bus = 8'h3c;
        step();
        op = 0;
        for (int i = 0; i < 3; i++) begin
            address = ra[i];
            step();
            total++; if (o8 !== e8[i] || v8 !== 1'b1) begin bad++; $display("FAIL b2b8_%0d got %h/%b want %h/1", i, o8, v8, e8[i]); end
            total++; if (o5 !== e5[i] || v5 !== 1'b1) begin bad++; $display("FAIL b2b5_%0d got %h/%b want %h/1", i, o5, v5, e5[i]); end
        end
        sel = 0;
        step();
        total++; if (v8 !== 1'b0 || o8 !== 8'ha5) begin bad++; $display("FAIL b2b_end got %h/%b want a5/0", o8, v8); end
    endtask

    task automatic test_busy_ignore();
        int pv = 0, n = 0;
        sel = 1; op = 0; address = 3; clear = 1;
        step();
        clear = 0;
        total++; if (o8 !== 8'h55 || v8 !== 1'b1 || b8 !== 1'b1) begin bad++; $display("FAIL sel_clear got %h/%b/%b want 55/1/1", o8, v8, b8); end
        op = 1; address = 2; in_bus = 8'hff;
        for (int i = 0; i < 20 && b8; i++) begin
            n++;
            step();
            if (v8) pv++;
        end
        sel = 0;
        total++; if (n != 8 || pv != 0) begin bad++; $display("FAIL busy_ign got busy=%0d pulses=%0d want 8/0", n, pv); end
        #1;
        total++; if (s8 !== 8'h00) begin bad++; $display("FAIL busy_mem2 got %h want 00", s8); end
        total++; if (s5 !== peek(1, 2)) begin bad++; $display("FAIL busy_mem2_5 got %h want %h", s5, peek(1, 2)); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear = 1;
        step();
        clear = 0;
        repeat (4) step();
        rst = 1; sel = 1; op = 0; address = 3;
        step();
        rst = 0; sel = 0;
        total++; if (o8 !== 8'h00 || v8 !== 1'b0 || o5 !== 4'h0 || v5 !== 1'b0) begin bad++; $display("FAIL rst_mid_out got %h/%b %h/%b want 0/0", o8, v8, o5, v5); end
        for (int i = 0; i < 20 && b8; i++) begin
            n++;
            step();
        end
        total++; if (n != 8) begin bad++; $display("FAIL rst_mid_len got %0d want 8", n); end
    endtask

    task automatic test_nonpow2();
        sel = 1; op = 1; address = 6; in_bus = 8'h09;
        step();
        sel = 0;
        total++; if (s5 !== 4'h0 || s8 !== 8'h09) begin bad++; $display("FAIL oor_wr got %h/%h want 0/09", s5, s8); end
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            total++; if (s5 !== peek(1, a)) begin bad++; $display("FAIL oor_mem_%0d got %h want %h", a, s5, peek(1, a)); end
        end
        sel = 1; op = 0; address = 6;
        step();
        sel = 0;
        total++; if (o5 !== 4'h0 || v5 !== 1'b1) begin bad++; $display("FAIL oor_rd got %h/%b want 0/1", o5, v5); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            clear = ($urandom_range(0, 29) == 0);
            sel = $urandom_range(0, 1);
            op = $urandom_range(0, 1);
            address = 3'($urandom);
            in_bus = 8'($urandom);
            step();
            total++; if (o8 !== om[0] || v8 !== vm[0] || b8 !== (left[0] > 0)) begin bad++; $display("FAIL rnd8_%0d got %h/%b/%b want %h/%b/%b", i, o8, v8, b8, om[0], vm[0], left[0] > 0); end
            total++; if (o5 !== om[1][3:0] || v5 !== vm[1] || b5 !== (left[1] > 0)) begin bad++; $display("FAIL rnd5_%0d got %h/%b/%b want %h/%b/%b", i, o5, v5, b5, om[1][3:0], vm[1], left[1] > 0); end
            total++; if (s8 !== peek(0, address) || s5 !== peek(1, address)) begin bad++; $display("FAIL rnd_sv_%0d got %h/%h want %h/%h", i, s8, s5, peek(0, address), peek(1, address)); end
        end
        rst = 0; clear = 0; sel = 0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            left[k] = 0;
            om[k] = 0;
            vm[k] = 0;
            for (int a = 0; a < 8; a++) mm[k][a] = 'x;
        end
        #2;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_nonpow2();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/memory_unit_sync.md
Name: memory_unit_sync

Overview:
Parametrised clocked successor to the 8x8 op/sel memory unit. It provides a single-port word-addressed array with a registered read path and a one-cycle read-valid strobe. A hardware clear sequencer zeroes every word after reset or on request. It sits between the bus controller and the datapath as local scratch storage. The debug tap `stored_value` is retained.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 8, number of words (>=2; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset: synchronous and active-high
- op  in  1  1 = write, 0 = read; sampled only when sel=1
- sel  in  1  request strobe; one operation per cycle with sel=1
- clear  in  1  starts a clear sweep from IDLE; ignored while busy
- address  in  ADDR_W  word address
- in_bus  in  WIDTH  write data
- out_bus  out  WIDTH  registered read data
- out_valid  out  1  one-cycle pulse: out_bus was updated by a read
- busy  out  1  1 while clear sweep is running; requests ignored
- stored_value  out  WIDTH  combinational view of mem[address]; 0 if address >= DEPTH

Behaviour:
- Reset (rst=1 at an edge): out_bus=0, out_valid=0, sweep counter=0, FSM->CLEAR, busy=1 from the following cycle. Array contents are not cleared by rst directly; the sweep clears them.
- Reset mid-sweep or mid-read restarts the sweep at address 0. A pending out_valid is cancelled.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[cnt] and increments cnt. When cnt == DEPTH-1 the final write occurs and the next state is IDLE. Exactly DEPTH cycles with busy=1.
  - IDLE: busy=0. clear=1 -> CLEAR with cnt=0; busy=1 from the next cycle.
- sel and clear asserted together in IDLE: the sel operation executes this cycle, then the sweep starts.
- In CLEAR, sel is ignored: no write, out_valid=0, out_bus holds its value.
- Write (IDLE, sel=1, op=1, address<DEPTH): mem[address]<=in_bus at the edge. stored_value shows the new data after the edge. out_bus and out_valid are unchanged (out_valid=0).
- Read (IDLE, sel=1, op=0): out_bus<=mem[address] at edge N, with out_valid=1 for the cycle after N.
  - Read latency is 1 clock.
  - out_bus holds its last read value indefinitely otherwise.
  - out_valid=0 in any cycle not following a read.
- Back-to-back: a write at edge N followed by a read of the same address at edge N+1 returns the new data. Reads every cycle give out_valid high continuously.
- Out-of-range address (address >= DEPTH, only possible when DEPTH is not a power of two): writes are dropped; reads return 0 with out_valid=1.
- sel=0: no array change, out_valid=0; op and in_bus are don't-care.
- stored_value is purely combinational, valid in every state including CLEAR. In CLEAR it shows partially cleared contents.

Test Plan:
- Reset/sweep (defaults): rst=1 for 1 cycle -> busy=1 for exactly 8 cycles, then 0. out_bus=0, out_valid=0. stored_value=0 for all addresses 0..7.
- Write/read: write 8'h55 @3, then read @3 -> stored_value=8'h55 the cycle after the write. Next cycle after the read: out_bus=8'h55, out_valid=1 for one cycle, then 0 with out_bus held at 8'h55.
- Back-to-back stream: writes A5@0, 3C@7, then reads 0,7,0 on consecutive cycles -> out_bus A5,3C,A5 with out_valid high 3 consecutive cycles.
- Ignore while busy: assert clear, then issue write 8'hFF @2 during sweep -> after busy falls, mem[2]=0 and out_valid never pulses during the sweep.
- Reset mid-operation: rst at sweep cycle 4 -> sweep restarts and busy lasts 8 more cycles. Read issued on the same edge as rst yields out_valid=0 and out_bus=0.
- Non-power-of-two (WIDTH=4, DEPTH=5): write 4'h9 @6 is dropped, all mem unchanged. Read @6 -> out_bus=0, out_valid=1. Reset sweep lasts 5 cycles.
